// File: rtl/median_pkg.sv
// Shared constants and types for the 3x3 median filter.
package median_pkg;

    // Default pixel width.
    localparam int unsigned PIX_W_DEF = 8;

    // Window geometry and sorting schedule: five max-extraction passes over
    // nine values.
    localparam int unsigned WIN_SIZE = 9;
    localparam int unsigned N_PASS   = 5;
    localparam int unsigned N_STEP   = 8;

    // Counter widths. The byte counter holds 0..9, step holds 0..7 and
    // pass holds 0..4.
    localparam int unsigned BYTE_CNT_W = $clog2(WIN_SIZE + 1);
    localparam int unsigned STEP_CNT_W = $clog2(N_STEP);
    localparam int unsigned PASS_CNT_W = $clog2(N_PASS);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad    = 3'd1,
        StCompare = 3'd2,
        StDiscard = 3'd3,
        StDone    = 3'd4
    } state_e;

endpackage

// File: rtl/MCE.sv
// Unsigned compare-exchange cell: routes the larger input to MAX and the
// smaller to MIN. On a tie both outputs carry the common value.
module MCE
    import median_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEF
) (
    input  logic [PIX_W-1:0] A,
    input  logic [PIX_W-1:0] B,
    output logic [PIX_W-1:0] MAX,
    output logic [PIX_W-1:0] MIN
);

    // Order the two operands.
    always_comb begin
        if (A > B) begin
            MAX = A;
            MIN = B;
        end else begin
            MAX = B;
            MIN = A;
        end
    end

endmodule

// File: rtl/median.sv
// Nine-sample median filter. Samples are shifted into a nine-entry register
// chain, then five passes each bubble the current maximum into R8 using a
// single compare-exchange cell. The first four maxima are discarded and
// replaced by zero, so the fifth pass leaves the median in R8.
module median
    import median_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEF
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [PIX_W-1:0] DI,
    input  logic             DSI,
    output logic [PIX_W-1:0] DO,
    output logic             DSO,
    output logic             BUSY
);

    // r_q[0] is R0 (newest sample), r_q[WIN_SIZE-1] is R8.
    logic [WIN_SIZE-1:0][PIX_W-1:0] r_q, r_d;

    state_e                state_q, state_d;
    logic [BYTE_CNT_W-1:0] byte_q, byte_d;
    logic [STEP_CNT_W-1:0] step_q, step_d;
    logic [PASS_CNT_W-1:0] pass_q, pass_d;

    logic [PIX_W-1:0] mce_max;
    logic [PIX_W-1:0] mce_min;

    // R7 and R8 are compared every cycle; the result is only used in COMPARE.
    MCE #(
        .PIX_W (PIX_W)
    ) u_mce (
        .A   (r_q[WIN_SIZE-2]),
        .B   (r_q[WIN_SIZE-1]),
        .MAX (mce_max),
        .MIN (mce_min)
    );

    // Next-state logic for the FSM, counters and the register chain.
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        step_d  = step_q;
        pass_d  = pass_q;
        r_d     = r_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (state_q == StDone) begin
                    state_d = StIdle;
                end
                // A strobe in DONE starts the next window without a gap.
                if (DSI) begin
                    r_d     = {r_q[WIN_SIZE-2:0], DI};
                    byte_d  = BYTE_CNT_W'(1);
                    state_d = StLoad;
                end
            end

            StLoad: begin
                if (DSI) begin
                    r_d    = {r_q[WIN_SIZE-2:0], DI};
                    byte_d = byte_q + 1'b1;
                    if (byte_q == BYTE_CNT_W'(WIN_SIZE - 1)) begin
                        step_d  = '0;
                        pass_d  = '0;
                        state_d = StCompare;
                    end
                end else begin
                    // Strobe dropped early: abandon the partial window.
                    byte_d  = '0;
                    state_d = StIdle;
                end
            end

            StCompare: begin
                // Rotate R0..R7 by one while R8 accumulates the running max.
                r_d    = {mce_max, r_q[WIN_SIZE-3:0], mce_min};
                step_d = step_q + 1'b1;
                if (step_q == STEP_CNT_W'(N_STEP - 1)) begin
                    step_d = '0;
                    if (pass_q == PASS_CNT_W'(N_PASS - 1)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StDiscard;
                    end
                end
            end

            StDiscard: begin
                // Drop the max in R8; the zero fill can never win a later pass.
                r_d     = {r_q[WIN_SIZE-2:0], PIX_W'(0)};
                pass_d  = pass_q + 1'b1;
                step_d  = '0;
                state_d = StCompare;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
            byte_q  <= '0;
            step_q  <= '0;
            pass_q  <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            step_q  <= step_d;
            pass_q  <= pass_d;
            r_q     <= r_d;
        end
    end

    assign DO   = r_q[WIN_SIZE-1];
    assign DSO  = (state_q == StDone);
    assign BUSY = (state_q == StLoad) || (state_q == StCompare) || (state_q == StDiscard);

endmodule

// File: tb/tb_median.sv
// Directed and randomised checks for the median filter.
module tb_median;

    typedef logic [7:0] win_t [9];

    logic       CLK;
    logic       nRST;
    logic [7:0] DI;
    logic       DSI;
    logic [7:0] DO;
    logic       DSO;
    logic       BUSY;

    int n_checks;
    int n_errors;
    int dso_cnt;
    int exp_windows;
    int lat;

    win_t win;

    median #(
        .PIX_W (8)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .DI   (DI),
        .DSI  (DSI),
        .DO   (DO),
        .DSO  (DSO),
        .BUSY (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count result strobes, sampled away from the active edge.
    always @(negedge CLK) begin
        if (DSO === 1'b1) dso_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] median_model(input win_t v);
        win_t       s;
        logic [7:0] t;
        s = v;
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (s[j] > s[j+1]) begin
                    t      = s[j];
                    s[j]   = s[j+1];
                    s[j+1] = t;
                end
            end
        end
        return s[4];
    endfunction

    // Called just after a rising edge; returns just after the 9th sampling edge.
    task automatic load(input win_t v);
        for (int i = 0; i < 9; i++) begin
            DSI = 1'b1;
            DI  = v[i];
            @(posedge CLK);
            #1;
        end
        DSI = 1'b0;
        exp_windows++;
    endtask

    // Counts edges until DSO, bounded; returns in the DONE cycle.
    task automatic wait_done(input string tag, input logic [7:0] exp);
        lat = 0;
        while (DSO !== 1'b1 && lat < 100) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 44);
        check({tag, "_do"}, DO, exp);
    endtask

    // One cycle after DONE: strobe gone, block idle.
    task automatic post_check(input string tag);
        @(posedge CLK);
        #1;
        check({tag, "_dso_low"}, DSO, 0);
        check({tag, "_busy_low"}, BUSY, 0);
    endtask

    task automatic run_window(input string tag, input win_t v, input logic [7:0] exp);
        load(v);
        wait_done(tag, exp);
        post_check(tag);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        dso_cnt     = 0;
        exp_windows = 0;
        DSI         = 1'b0;
        DI          = '0;
        nRST        = 1'b0;

        #1;
        check("rst_dso", DSO, 0);
        check("rst_busy", BUSY, 0);
        check("rst_do", DO, 0);
        repeat (3) @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        check("idle_busy", BUSY, 0);

        win = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        run_window("asc", win, 8'd5);

        win = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        run_window("desc", win, 8'd5);

        win = '{8'd200, 8'd0, 8'd255, 8'd17, 8'd17, 8'd17, 8'd90, 8'd3, 8'd250};
        run_window("mixed", win, 8'd17);

        win = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        run_window("zeros", win, 8'd0);

        win = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        run_window("max", win, 8'd255);

        // Partial window: five bytes then strobe dropped.
        for (int i = 0; i < 5; i++) begin
            DSI = 1'b1;
            DI  = 8'(i + 1);
            @(posedge CLK);
            #1;
        end
        DSI = 1'b0;
        @(posedge CLK);
        #1;
        check("abort_busy", BUSY, 0);
        repeat (50) @(posedge CLK);
        #1;
        check("abort_no_dso", dso_cnt, exp_windows);

        win = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        run_window("after_abort", win, 8'd5);

        // Reset in the middle of pass 2.
        load(win);
        exp_windows--;
        repeat (21) @(posedge CLK);
        #1;
        check("mid_busy", BUSY, 1);
        nRST = 1'b0;
        #1;
        check("mid_rst_dso", DSO, 0);
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_do", DO, 0);
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        repeat (50) @(posedge CLK);
        #1;
        check("mid_rst_no_dso", dso_cnt, exp_windows);
        check("mid_rst_idle", BUSY, 0);

        win = '{8'd7, 8'd7, 8'd7, 8'd1, 8'd1, 8'd1, 8'd9, 8'd9, 8'd9};
        run_window("sevens", win, 8'd7);

        // Back-to-back: the second load starts in the DONE cycle.
        win = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load(win);
        wait_done("b2b_a", 8'd5);
        win = '{8'd200, 8'd0, 8'd255, 8'd17, 8'd17, 8'd17, 8'd90, 8'd3, 8'd250};
        load(win);
        wait_done("b2b_b", 8'd17);
        post_check("b2b_b");

        // Random windows; every fourth uses a tiny range to force ties.
        for (int w = 0; w < 1000; w++) begin
            for (int i = 0; i < 9; i++) begin
                win[i] = 8'($urandom_range(0, (w % 4 == 0) ? 3 : 255));
            end
            load(win);
            wait_done("rand", median_model(win));
        end
        post_check("rand_end");

        check("dso_count", dso_cnt, exp_windows);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
